// File: rtl/sample_sequencer_pkg.sv
// Shared types and default parameter values for the sample playback sequencer.
package sample_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_SAMPLE_W = 12;
  localparam int DEF_ACC_W    = 16;
  localparam int DEF_DIV_W    = 16;

endpackage

// File: rtl/sample_sequencer_rate_divider.sv
// Tick generator: counts 0..period while enabled and flags the terminal count.
module rate_divider
  import sample_sequencer_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  assign tick = enable && !clear && (count == period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/sample_sequencer.sv
// Phase-accumulator sample playback: fetches samples at a divided rate and
// presents each one two cycles after its read strobe.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | accepting configuration, waiting for start
// ST_RUN   | divider running, one memory read per tick
// ST_DRAIN | stopped, waiting for in-flight reads to deliver their sample
module sample_sequencer
  import sample_sequencer_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int DIV_W    = DEF_DIV_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [ACC_W-1:0]    cfg_step,
  input  logic [DIV_W-1:0]    cfg_div,
  output logic                mem_read,
  output logic [ADDR_W-1:0]   mem_address,
  input  logic [SAMPLE_W-1:0] mem_sample,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                wrap,
  output logic                busy
);

  // Reset step advances the address by exactly one entry per tick.
  localparam logic [ACC_W-1:0] STEP_RST = ACC_W'(1) << (ACC_W - ADDR_W);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   step_reg;
  logic [DIV_W-1:0]   div_reg;
  logic [ACC_W:0]     acc_sum;
  logic               rd_pend;
  logic               tick;
  logic               div_clear;
  logic               div_enable;

  assign acc_sum    = {1'b0, acc} + {1'b0, step_reg};
  assign cfg_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign div_enable = (state == ST_RUN);
  assign div_clear  = (state != ST_RUN);

  rate_divider #(
    .DIV_W(DIV_W)
  ) u_rate_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (div_clear),
    .enable(div_enable),
    .period(div_reg),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      acc          <= '0;
      step_reg     <= STEP_RST;
      div_reg      <= '0;
      mem_read     <= 1'b0;
      mem_address  <= '0;
      rd_pend      <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      mem_read     <= 1'b0;
      wrap         <= 1'b0;
      // Memory answers one cycle after the strobe; the sample is then registered.
      rd_pend      <= mem_read;
      sample_valid <= rd_pend;
      if (rd_pend) sample_out <= mem_sample;

      case (state)
        ST_IDLE: begin
          if (cfg_valid) begin
            step_reg <= cfg_step;
            div_reg  <= cfg_div;
          end
          if (start) begin
            state <= ST_RUN;
            acc   <= '0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_DRAIN;
          end else if (tick) begin
            mem_read    <= 1'b1;
            mem_address <= acc[ACC_W-1 -: ADDR_W];
            acc         <= acc_sum[ACC_W-1:0];
            wrap        <= acc_sum[ACC_W];
          end
        end
        ST_DRAIN: begin
          if (!mem_read && !rd_pend) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_sequencer.sv
// Randomized self-checking bench for sample_sequencer with an arithmetic playback model.
module tb_sample_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, cfg_valid, cfg_ready;
  logic [15:0] cfg_step, cfg_div;
  logic        mem_read;
  logic [4:0]  mem_address;
  logic [11:0] mem_sample;
  logic [11:0] sample_out;
  logic        sample_valid, wrap, busy;

  logic [11:0] mem [32];
  int tests  = 0;
  int failed = 0;

  sample_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_step(cfg_step), .cfg_div(cfg_div),
    .mem_read(mem_read), .mem_address(mem_address), .mem_sample(mem_sample),
    .sample_out(sample_out), .sample_valid(sample_valid), .wrap(wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous sample memory: data valid the cycle after the strobe.
  always @(posedge clk) if (mem_read) mem_sample <= mem[mem_address];

  // Address of the k-th read (k>=1): top 5 bits of (k-1)*step mod 2^16.
  function automatic int exp_addr(input int k, input int s);
    longint a;
    a = longint'(k - 1) * longint'(s);
    return int'((a % 65536) / 2048);
  endfunction

  // The k-th read wraps when k*step crosses a multiple of 2^16.
  function automatic bit exp_wrap(input int k, input int s);
    return ((longint'(k) * s) / 65536) != ((longint'(k - 1) * s) / 65536);
  endfunction

  task automatic test_reset();
    tests++; if (mem_read !== 1'b0) begin failed++; $display("FAIL reset_mem_read got %b exp 0", mem_read); end
    tests++; if (mem_address !== 5'd0) begin failed++; $display("FAIL reset_mem_address got %0d exp 0", mem_address); end
    tests++; if (sample_out !== 12'd0) begin failed++; $display("FAIL reset_sample_out got %0h exp 0", sample_out); end
    tests++; if (sample_valid !== 1'b0) begin failed++; $display("FAIL reset_sample_valid got %b exp 0", sample_valid); end
    tests++; if (wrap !== 1'b0) begin failed++; $display("FAIL reset_wrap got %b exp 0", wrap); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (cfg_ready !== 1'b1) begin failed++; $display("FAIL reset_cfg_ready got %b exp 1", cfg_ready); end
  endtask

  task automatic test_playback(input string name, input int s, input int d, input bit use_cfg, input int n);
    bit exp_rd, exp_sv;
    int rd_k, sv_k;
    @(negedge clk);
    if (use_cfg) begin cfg_valid = 1'b1; cfg_step = 16'(s); cfg_div = 16'(d); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; cfg_valid = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      exp_rd = (c % (d + 1)) == 0;
      exp_sv = (c - 2 >= d + 1) && ((c - 2) % (d + 1) == 0);
      rd_k = c / (d + 1);
      sv_k = (c - 2) / (d + 1);
      tests++; if (mem_read !== exp_rd) begin failed++; $display("FAIL %s mem_read c=%0d got %b exp %b", name, c, mem_read, exp_rd); end
      tests++; if (sample_valid !== exp_sv) begin failed++; $display("FAIL %s sample_valid c=%0d got %b exp %b", name, c, sample_valid, exp_sv); end
      tests++; if (wrap !== (exp_rd && exp_wrap(rd_k, s))) begin failed++; $display("FAIL %s wrap c=%0d got %b exp %b", name, c, wrap, exp_rd && exp_wrap(rd_k, s)); end
      tests++; if (busy !== 1'b1) begin failed++; $display("FAIL %s busy c=%0d got %b exp 1", name, c, busy); end
      if (rd_k >= 1) begin
        tests++; if (mem_address !== 5'(exp_addr(rd_k, s))) begin failed++; $display("FAIL %s mem_address c=%0d got %0d exp %0d", name, c, mem_address, exp_addr(rd_k, s)); end
      end
      if (c - 2 >= d + 1) begin
        tests++; if (sample_out !== mem[exp_addr(sv_k, s)]) begin failed++; $display("FAIL %s sample_out c=%0d got %0h exp %0h", name, c, sample_out, mem[exp_addr(sv_k, s)]); end
      end
    end
    stop = 1'b1;
    for (int i = 0; i < 16 && busy; i++) @(negedge clk);
    stop = 1'b0;
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL %s drain_to_idle got busy=%b exp 0", name, busy); end
  endtask

  task automatic test_drain();
    bit seen = 1'b0;
    int pulses = 0, reads = 0;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_step = 16'($urandom_range(1, 65535)); cfg_div = 16'd3; start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = (mem_read === 1'b1); end
    tests++; if (!seen) begin failed++; $display("FAIL drain_first_read got none exp read within 20 cycles"); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL drain_busy got %b exp 1", busy); end
    tests++; if (cfg_ready !== 1'b0) begin failed++; $display("FAIL drain_cfg_ready got %b exp 0", cfg_ready); end
    pulses += int'(sample_valid === 1'b1);
    reads  += int'(mem_read === 1'b1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      pulses += int'(sample_valid === 1'b1);
      reads  += int'(mem_read === 1'b1);
    end
    tests++; if (pulses != 1) begin failed++; $display("FAIL drain_pulses got %0d exp 1", pulses); end
    tests++; if (reads != 0) begin failed++; $display("FAIL drain_reads got %0d exp 0", reads); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL drain_idle_busy got %b exp 0", busy); end
    tests++; if (cfg_ready !== 1'b1) begin failed++; $display("FAIL drain_idle_cfg_ready got %b exp 1", cfg_ready); end
  endtask

  task automatic test_cfg_in_run();
    int s1, d1;
    s1 = int'($urandom_range(1, 65535));
    d1 = int'($urandom_range(0, 3));
    @(negedge clk);
    cfg_valid = 1'b1; cfg_step = 16'(s1); cfg_div = 16'(d1); start = 1'b1;
    @(negedge clk);
    start = 1'b0; cfg_step = ~16'(s1); cfg_div = 16'(d1 + 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (cfg_ready !== 1'b0) begin failed++; $display("FAIL cfg_in_run cfg_ready got %b exp 0", cfg_ready); end
    end
    cfg_valid = 1'b0; stop = 1'b1;
    for (int i = 0; i < 16 && busy; i++) @(negedge clk);
    stop = 1'b0;
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL cfg_in_run drain got busy=%b exp 0", busy); end
    test_playback("cfg_held", s1, d1, 1'b0, 30);
  endtask

  task automatic test_start_stop();
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL start_stop_idle busy got %b exp 1", busy); end
    tests++; if (cfg_ready !== 1'b0) begin failed++; $display("FAIL start_stop_idle cfg_ready got %b exp 0", cfg_ready); end
    repeat (4) @(negedge clk);
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL start_stop_run busy got %b exp 1", busy); end
    stop = 1'b1;
    for (int i = 0; i < 16 && busy; i++) @(negedge clk);
    stop = 1'b0;
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL start_stop drain got busy=%b exp 0", busy); end
  endtask

  task automatic test_reset_midrun();
    int nreads = 0, pulses = 0, reads = 0;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_step = 16'h1800; cfg_div = 16'd3; start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    for (int i = 0; i < 30 && nreads < 2; i++) begin
      @(negedge clk);
      nreads += int'(mem_read === 1'b1);
    end
    tests++; if (nreads != 2) begin failed++; $display("FAIL midrun_reads got %0d exp 2", nreads); end
    rst_n = 1'b0;
    #1;
    tests++; if (mem_read !== 1'b0) begin failed++; $display("FAIL midrun_rst mem_read got %b exp 0", mem_read); end
    tests++; if (mem_address !== 5'd0) begin failed++; $display("FAIL midrun_rst mem_address got %0d exp 0", mem_address); end
    tests++; if (sample_out !== 12'd0) begin failed++; $display("FAIL midrun_rst sample_out got %0h exp 0", sample_out); end
    tests++; if (sample_valid !== 1'b0 || wrap !== 1'b0) begin failed++; $display("FAIL midrun_rst pulses got sv=%b wrap=%b exp 0 0", sample_valid, wrap); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL midrun_rst busy got %b exp 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pulses += int'(sample_valid === 1'b1);
      reads  += int'(mem_read === 1'b1);
    end
    tests++; if (pulses != 0) begin failed++; $display("FAIL midrun_after pulses got %0d exp 0", pulses); end
    tests++; if (reads != 0) begin failed++; $display("FAIL midrun_after reads got %0d exp 0", reads); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 12'($urandom_range(1, 4095));
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    cfg_step = '0; cfg_div = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_playback("default", 2048, 0, 1'b0, 72);
    test_playback("div3_step1000", 16'h1000, 3, 1'b1, 4 * 18);
    test_playback("step0", 0, int'($urandom_range(0, 3)), 1'b1, 40);
    for (int r = 0; r < 4; r++)
      test_playback("random", int'($urandom_range(0, 65535)), int'($urandom_range(0, 5)), 1'b1, 60);
    test_drain();
    test_cfg_in_run();
    test_start_stop();
    test_reset_midrun();
    test_playback("post_reset", 2048, 0, 1'b0, 40);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sample_sequencer.md
SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 Parameter ADDR_W, default 5, sample memory address width; depth 2^ADDR_W.
REQ-002 Parameter SAMPLE_W, default 12, sample width.
REQ-003 Parameter ACC_W, default 16, phase accumulator width (ACC_W > ADDR_W).
REQ-004 Parameter DIV_W, default 16, rate divider width.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  level, sampled per cycle; begin playback.
REQ-008 stop  input  1  level, sampled per cycle; end playback.
REQ-009 cfg_valid  input  1  configuration offer.
REQ-010 cfg_ready  output  1  configuration accepted this cycle when high with cfg_valid.
REQ-011 cfg_step  input  ACC_W  phase increment per tick.
REQ-012 cfg_div  input  DIV_W  tick period minus one, in clk cycles.
REQ-013 mem_read  output  1  read strobe to sample memory.
REQ-014 mem_address  output  ADDR_W  read address to sample memory.
REQ-015 mem_sample  input  SAMPLE_W  memory data, valid the cycle after mem_read.
REQ-016 sample_out  output  SAMPLE_W  last fetched sample, held between updates.
REQ-017 sample_valid  output  1  one-cycle pulse, sample_out updated.
REQ-018 wrap  output  1  one-cycle pulse, accumulator overflowed.
REQ-019 busy  output  1  high in RUN or DRAIN.

Function
REQ-020 FSM SHALL have states IDLE, RUN, DRAIN.
REQ-021 IDLE: cfg_ready=1; cfg_valid&cfg_ready SHALL load step_reg<=cfg_step, div_reg<=cfg_div.
REQ-022 IDLE+start SHALL go RUN, clearing accumulator and divider count; start and cfg handshake same cycle: config loads, takes effect on the new run.
REQ-023 RUN/DRAIN: cfg_ready=0; start ignored.
REQ-024 Divider SHALL count 0..div_reg, asserting internal tick when count==div_reg, then wrap to 0; div_reg=0 ticks every RUN cycle; first tick div_reg+1 cycles after entering RUN.
REQ-025 On tick in RUN: mem_read=1 for that cycle, mem_address=acc[ACC_W-1:ACC_W-ADDR_W], acc<=acc+step_reg modulo 2^ACC_W.
REQ-026 mem_read=0 and mem_address held at last value when no tick.
REQ-027 Cycle after mem_read, block SHALL register sample_out<=mem_sample; sample_valid SHALL be high the following cycle (latency 2 cycles, read cycle to pulse).
REQ-028 wrap SHALL pulse the cycle after a tick whose addition carried out of bit ACC_W-1.
REQ-029 step_reg=0: address constant, sample_valid still pulses every tick.
REQ-030 RUN+stop SHALL go DRAIN (no tick issued that cycle); stop wins over a coincident tick.
REQ-031 DRAIN SHALL go IDLE once no read is in flight; in-flight sample still emits sample_valid.
REQ-032 start and stop together in IDLE: start wins; in RUN: stop wins.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, acc=0, divider=0, mem_read=0, mem_address=0, sample_out=0, sample_valid=0, wrap=0, busy=0, step_reg=2^(ACC_W-ADDR_W), div_reg=0.
REQ-034 Reset mid-run SHALL discard in-flight reads; no sample_valid after release until a new tick.

Structure
REQ-035 Shared package SHALL hold FSM state enumeration and default parameter constants.
REQ-036 Divider SHALL be sub-module rate_divider (inputs clk, rst_n, clear, enable, period; output tick).

Verification
REQ-037 Reset defaults, start, no cfg -> mem_address 0,1,2,... one per cycle, sample_valid 2 cycles after each mem_read, wrap after address 31.
REQ-038 cfg_div=3, cfg_step=0x1000 -> mem_read every 4 cycles, addresses 0,2,4,...,30,0; wrap every 16 ticks.
REQ-039 stop with read in flight -> DRAIN, exactly one more sample_valid, then IDLE, busy=0.
REQ-040 cfg_valid in RUN -> cfg_ready=0, step unchanged; start+stop together in IDLE -> RUN.
REQ-041 rst_n asserted between mem_read and sample_valid -> all outputs zero at once, no pulse after release.
REQ-042 cfg_step=0 -> mem_address constant, sample_valid every tick, wrap never.
